usr_shift_reg: RTL and testbench

//  Parameterised universal shift register: hold, shift right, shift left, parallel load.

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_shift_reg_mux4.sv | 30 +++
 rtl/usr_shift_reg.sv | 134 +++++++++++++
 tb/tb_usr_shift_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
//------------------------------------------------------------------------------
// Module : usr_pkg
// Brief  : Shared mode and FSM state encodings for usr_shift_reg.
// Rev    : 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SHIFTING = 1'b1
    } state_t;

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_shift_reg_mux4.sv
//------------------------------------------------------------------------------
// Module : mux4
// Brief  : 1-bit 4:1 mux selecting a register bit's next value by mode.
// Rev    : 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux4 (
    input  logic [1:0] sel,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic       y
);

    always_comb begin
        y = in0;
        case (sel)
            2'b00:   y = in0;
            2'b01:   y = in1;
            2'b10:   y = in2;
            2'b11:   y = in3;
            default: y = in0;
        endcase
    end

endmodule : mux4

`default_nettype wire

// File: rtl/usr_shift_reg.sv
//------------------------------------------------------------------------------
// Module : usr_shift_reg
// Brief  : Universal shift register (hold/shr/shl/load) with shift-count FSM.
//          Optional rotate mode enabled by defining USR_ROTATE_EN.
// Rev    : 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam int               c_cnt_w     = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_shift_max = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    mode_t              w_mode;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   w_shr;
    logic [WIDTH-1:0]   w_shl;
    logic               w_sr_in;
    logic               w_sl_in;
    logic               w_is_shift;

    assign w_mode = mode_t'(mode);

`ifdef USR_ROTATE_EN
    assign w_sr_in = rot ? r_q[0]       : sin_r;
    assign w_sl_in = rot ? r_q[WIDTH-1] : sin_l;
`else
    logic w_unused_rot;
    assign w_unused_rot = rot;
    assign w_sr_in      = sin_r;
    assign w_sl_in      = sin_l;
`endif

    assign w_shr = {w_sr_in, r_q[WIDTH-1:1]};
    assign w_shl = {r_q[WIDTH-2:0], w_sl_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux4 u_mux4 (
            .sel (mode),
            .in0 (r_q[i]),
            .in1 (w_shr[i]),
            .in2 (w_shl[i]),
            .in3 (d[i]),
            .y   (w_q_nxt[i])
        );
    end

    assign w_is_shift = (w_mode == MODE_SHR) || (w_mode == MODE_SHL);

    // Count only advances in SHIFTING; shifts while IDLE move data but are not tracked.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mode == MODE_LOAD) begin
                        w_state_nxt = ST_SHIFTING;
                        w_count_nxt = '0;
                    end
                end
                ST_SHIFTING: begin
                    if (w_mode == MODE_LOAD) begin
                        w_count_nxt = '0;
                    end else if (w_is_shift) begin
                        if ((r_count + c_cnt_one) == c_shift_max) begin
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_count_nxt = r_count + c_cnt_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (en) begin
                r_state <= w_state_nxt;
                r_count <= w_count_nxt;
                r_q     <= w_q_nxt;
            end
        end
    end

    assign q      = r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];
    assign busy   = (r_state == ST_SHIFTING);
    assign done   = r_done;

endmodule : usr_shift_reg

`default_nettype wire

// File: tb/tb_usr_shift_reg.sv
//------------------------------------------------------------------------------
// Module : tb_usr_shift_reg
// Brief  : Directed plus random stimulus against a behavioural model of usr_shift_reg.
// Rev    : 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_usr_shift_reg;

    localparam int W = 4;
`ifdef USR_ROTATE_EN
    localparam bit c_rot_en = 1'b1;
`else
    localparam bit c_rot_en = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin_r = 1'b0;
    logic         sin_l = 1'b0;
    logic [W-1:0] d = '0;
    logic         rot = 1'b0;
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic         busy;
    logic         done;

    usr_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d      (d),
        .rot    (rot),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: contents, whether a loaded word is in flight, shifts since load.
    logic [W-1:0] m_q    = '0;
    bit           m_act  = 1'b0;
    int           m_cnt  = 0;
    bit           m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rs, input bit e, input logic [1:0] m,
                              input bit sr, input bit sl, input logic [W-1:0] dd, input bit rt);
        bit shifted;
        bit bin;
        shifted = 1'b0;
        m_done  = 1'b0;
        if (rs) begin
            m_q   = '0;
            m_act = 1'b0;
            m_cnt = 0;
        end else if (e) begin
            case (m)
                2'd1: begin
                    bin     = (c_rot_en && rt) ? m_q[0] : sr;
                    m_q     = (m_q >> 1) | (W'(bin) << (W - 1));
                    shifted = 1'b1;
                end
                2'd2: begin
                    bin     = (c_rot_en && rt) ? m_q[W-1] : sl;
                    m_q     = W'((m_q << 1) | W'(bin));
                    shifted = 1'b1;
                end
                2'd3: begin
                    m_q   = dd;
                    m_act = 1'b1;
                    m_cnt = 0;
                end
                default: ;
            endcase
            if (shifted && m_act) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_done = 1'b1;
                    m_act  = 1'b0;
                    m_cnt  = 0;
                end
            end
        end
    endtask

    task automatic step(input bit rs, input bit e, input logic [1:0] m,
                        input bit sr, input bit sl, input logic [W-1:0] dd, input bit rt);
        @(negedge clk);
        reset = rs; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd; rot = rt;
        @(posedge clk);
        #1;
        model_step(rs, e, m, sr, sl, dd, rt);
        check("q",      32'(q),      32'(m_q));
        check("sout_r", 32'(sout_r), 32'(m_q[0]));
        check("sout_l", 32'(sout_l), 32'(m_q[W-1]));
        check("busy",   32'(busy),   32'(m_act));
        check("done",   32'(done),   32'(m_done));
    endtask

    initial begin
        // Reset with load request pending: reset must win
        repeat (2) step(1, 1, 2'b11, 0, 0, 4'hF, 0);

        // Load then four right shifts
        step(0, 1, 2'b11, 0, 0, 4'b1011, 0);
        repeat (4) step(0, 1, 2'b01, 0, 0, 4'h0, 0);
        step(0, 1, 2'b00, 0, 0, 4'h0, 0);

        // Left shifts with enable gaps
        step(0, 1, 2'b11, 0, 0, 4'b0001, 0);
        repeat (2) step(0, 1, 2'b10, 0, 1, 4'h0, 0);
        repeat (2) step(0, 0, 2'b10, 0, 1, 4'h0, 0);
        repeat (2) step(0, 1, 2'b10, 0, 1, 4'h0, 0);
        step(0, 1, 2'b00, 0, 0, 4'h0, 0);

        // Reload mid-word restarts the count
        step(0, 1, 2'b11, 0, 0, 4'b1100, 0);
        repeat (2) step(0, 1, 2'b01, 1, 0, 4'h0, 0);
        step(0, 1, 2'b11, 0, 0, 4'b0110, 0);
        repeat (4) step(0, 1, 2'b10, 0, 0, 4'h0, 0);
        step(0, 1, 2'b00, 0, 0, 4'h0, 0);

        // Reset mid-word abandons it
        step(0, 1, 2'b11, 0, 0, 4'b1010, 0);
        repeat (2) step(0, 1, 2'b01, 0, 0, 4'h0, 0);
        step(1, 1, 2'b01, 0, 0, 4'h0, 0);
        repeat (4) step(0, 1, 2'b01, 0, 0, 4'h0, 0);

        // Rotate-left request (rotates only when the feature is built in)
        step(0, 1, 2'b11, 0, 0, 4'b1000, 1);
        repeat (4) step(0, 1, 2'b10, 0, 0, 4'h0, 1);
        step(0, 1, 2'b00, 0, 0, 4'h0, 1);

        // Mixed direction shifts both count
        step(0, 1, 2'b11, 0, 0, 4'b0110, 0);
        step(0, 1, 2'b01, 1, 0, 4'h0, 0);
        step(0, 1, 2'b10, 0, 1, 4'h0, 0);
        step(0, 1, 2'b01, 0, 0, 4'h0, 1);
        step(0, 1, 2'b10, 1, 0, 4'h0, 1);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 W'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_usr_shift_reg

`default_nettype wire
